// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch path: single outstanding request, fixed access latency,
// valid/ready on both sides, plus a side load port for filling the program array.
module imem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [31:0]   mem_r [DEPTH_WORDS];

    logic          req_ok_s;
    logic          ld_ok_s;
    logic          accept_s;
    logic [31:0]   rd_word_s;

    // Aligned and inside the array, judged on the full 32-bit address so high bits never alias.
    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> (AW + 2)) == 32'd0);
    endfunction

    assign req_ok_s  = addr_ok(req_addr);
    assign ld_ok_s   = addr_ok(ld_addr);
    assign accept_s  = req_valid && req_ready;
    assign rd_word_s = mem_r[req_addr[AW+1:2]];

    // Program array load port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!reset && ld_en && ld_ok_s) begin
            mem_r[ld_addr[AW+1:2]] <= ld_data;
        end
    end

    // Request/response FSM. The word is captured at the accept edge, so a same-edge load
    // (non-blocking) leaves the response with the old contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_instr <= 32'd0;
            rsp_addr  <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        rsp_addr  <= req_addr;
                        rsp_err   <= !req_ok_s;
                        rsp_instr <= req_ok_s ? rd_word_s : 32'd0;
                        cnt_r     <= CNT_INIT;
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state_r   <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r   <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r   <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= {CW{1'b0}};
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: stimulus pushes expected responses, a monitor pops on handshake.
module tb_imem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = 32'd0;
    logic [31:0] ld_data = 32'd0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_edge = 0;
    int prev_acc = -100;
    logic prev_vld = 1'b0;

    logic [31:0] stream_data [8] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193,
                                     32'h00400213, 32'h00500293, 32'h00600313, 32'h00700393};

    imem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_addr(rsp_addr), .rsp_err(rsp_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Monitor: latency, accept spacing and scoreboard comparison at each response handshake.
    always @(negedge clk) begin
        if (reset) begin
            prev_vld <= 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                if (prev_acc >= 0) chk("accept_spacing_ok", 32'((cyc + 1 - prev_acc) >= LAT + 1), 32'd1);
                prev_acc <= cyc + 1;
                acc_edge <= cyc + 1;
            end
            if (rsp_valid && !prev_vld) chk("latency", 32'(cyc - acc_edge), 32'(LAT));
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got addr %h, required no response", rsp_addr);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_addr", rsp_addr, e.addr);
                    chk("rsp_instr", rsp_instr, e.instr);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
            prev_vld <= rsp_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ee, input bit expect_rsp);
        exp_t e;
        wait_ready();
        req_valid = 1'b1;
        req_addr = a;
        e.addr = a;
        e.instr = ei;
        e.err = ee;
        if (expect_rsp) q.push_back(e);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !req_ready) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_pending", 32'(q.size()), 32'd0);
    endtask

    initial begin
        exp_t e;
        int n;

        repeat (2) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_instr", rsp_instr, 32'd0);
        chk("reset_rsp_addr", rsp_addr, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Fill program words, including loads that must be dropped (misaligned / out of range).
        load(32'h0000_0000, 32'h2008_0005);
        load(32'h0000_0004, 32'h0040_0013);
        load(32'h0000_0006, 32'h1234_5678);
        load(32'h4000_0000, 32'hBAD0_BAD0);
        load(32'h0000_03FC, 32'hDEAD_BEEF);
        load(32'h0000_0008, 32'h1111_1111);

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        fetch(32'h0000_0000, 32'h2008_0005, 1'b0, 1'b1);
        drain();

        // Backpressure: response must hold steady while rsp_ready is low.
        rsp_ready = 1'b0;
        fetch(32'h0000_0004, 32'h0040_0013, 1'b0, 1'b1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_instr", rsp_instr, 32'h0040_0013);
            chk("hold_rsp_addr", rsp_addr, 32'h0000_0004);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        drain();
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        // Error cases and the last valid word.
        fetch(32'h0000_0006, 32'h0000_0000, 1'b1, 1'b1);
        fetch(32'h0000_0400, 32'h0000_0000, 1'b1, 1'b1);
        fetch(32'h0000_03FC, 32'hDEAD_BEEF, 1'b0, 1'b1);
        fetch(32'h4000_0000, 32'h0000_0000, 1'b1, 1'b1);
        fetch(32'h0000_0000, 32'h2008_0005, 1'b0, 1'b1);
        drain();

        // Same-edge load and accept of word 0x8: old word returned, new word on next read.
        wait_ready();
        req_valid = 1'b1;
        req_addr = 32'h0000_0008;
        ld_en = 1'b1;
        ld_addr = 32'h0000_0008;
        ld_data = 32'hFFFF_FFFF;
        e.addr = 32'h0000_0008;
        e.instr = 32'h1111_1111;
        e.err = 1'b0;
        q.push_back(e);
        tick();
        req_valid = 1'b0;
        ld_en = 1'b0;
        fetch(32'h0000_0008, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drain();

        // Reset while waiting aborts the request; array contents survive.
        fetch(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        fetch(32'h0000_0000, 32'h2008_0005, 1'b0, 1'b1);
        drain();

        // Sequential PC stream.
        for (int i = 0; i < 8; i++) load(32'(i * 4), stream_data[i]);
        for (int i = 0; i < 8; i++) fetch(32'(i * 4), stream_data[i], 1'b0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
